chunk_serializer: RTL and testbench
===================================

Name: chunk_serializer

Overview:
- Parametrised successor of the chunk divider. Latches one data block plus an optional crypto header (public key, nonce, counter) and emits it as a stream of WORD_W-bit words.
- Uses a full AXI-Stream valid/ready/last handshake and exposes input-side backpressure via ready.
- Sits between the ChaCha/cipher core output and the DMA-facing AXI-Stream master.

Parameters:
- WORD_W, 32, output word width in bits.
- DATA_W, 512, data block width; must be a multiple of WORD_W.
- KEY_W, 256, public key width; multiple of WORD_W.
- NONCE_W, 64, nonce width; multiple of WORD_W.
- CTR_W, 64, counter width; multiple of WORD_W.

Ports:
- chunk_ser_clk  in  1  clock.
- chunk_ser_reset_n  in  1  asynchronous active-low reset.
- chunk_ser_valid  in  1  input block valid.
- chunk_ser_ready  out  1  block accepted when valid && ready.
- encryp_decryp  in  1  0 = ENCRYP (header+data), 1 = DECRYP (data only).
- public_key  in  KEY_W  header key.
- nonce  in  NONCE_W  header nonce.
- counter  in  CTR_W  header counter.
- chunk_ser_data_in  in  DATA_W  data block.
- m_axis_tdata  out  WORD_W  output word.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on the final word of a packet.

Behaviour:
- Reset is asynchronous and active-low. While reset is asserted: state=IDLE, chunk_ser_ready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, all capture registers=0. Reset asserted mid-packet aborts the packet immediately and does not complete it.
- chunk_ser_ready is 1 only in IDLE and out of reset.
- On a handshake (valid && ready), all inputs and encryp_decryp are latched. Later input or mode changes do not affect the packet in flight.
- States: IDLE, KEY, NONCE, CTR, DATA.
  - Accept with ENCRYP: IDLE→KEY.
  - Accept with DECRYP: IDLE→DATA.
  - Each segment is emitted most-significant word first, e.g. bits [KEY_W-1 -: WORD_W] first.
  - Order: KEY→NONCE→CTR→DATA.
- Latency: the first word is presented with tvalid=1 in the cycle after the accept.
- The output register advances when !m_axis_tvalid || m_axis_tready. While tvalid=1 and tready=0, tdata, tlast and tvalid hold stable (AXI rule).
- Throughput: one word per cycle while tready=1.
- tlast=1 coincides with the last DATA word (lowest word of the block), in both modes.
- On the handshake of the tlast word:
  - If no next word is loaded: tvalid drops to 0 in the next cycle.
  - State returns to IDLE and ready rises in the next cycle.
  - Minimum gap between packets is one idle cycle.
- Packet length in words:
  - ENCRYP: (KEY_W+NONCE_W+CTR_W+DATA_W)/WORD_W, which is 28 at defaults.
  - DECRYP: DATA_W/WORD_W, which is 16.
- Word index counter width is $clog2 of the largest segment word count, plus 1. The index reloads at each segment boundary; there is no wrap past 0.
- A zero-width segment is illegal and rejected by an elaboration-time check, as is any width that is not a multiple of WORD_W.

Optional Feature:
- Macro CHUNK_SER_STATS_EN.
- When defined: adds output port pkt_count (32 bits).
  - Increments on each tlast handshake.
  - Wraps 0xFFFFFFFF→0.
  - Reset to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package chunk_ser_pkg holds:
  - state enum (IDLE/KEY/NONCE/CTR/DATA);
  - mode localparams ENCRYP=1'b0, DECRYP=1'b1;
  - packet word-count constant functions.
- One sub-module: chunk_ser_out_reg, an AXI-Stream output register stage (tdata/tlast/tvalid with ready-driven load enable).
- The FSM and segment muxing stay in chunk_serializer.

Test Plan:
- ENCRYP, tready=1, key=0x00..1F byte pattern, nonce=0xA5A5_0000_0000_0001, counter=0x1, data=incrementing words 0x0F..0x00:
  - expect 28 beats: 8 key words MS first, 0xA5A50000, 0x00000001, 0x00000000, 0x00000001, then 16 data words;
  - tlast only on beat 28.
- DECRYP, same data: 16 beats with word 0x0000000F first, tlast on the 16th beat; ready rises 1 cycle after the last handshake.
- Random tready with 30% stalls, ENCRYP: tdata and tlast hold constant throughout every stall; received sequence matches the no-stall case.
- Toggle encryp_decryp and change data_in during an ENCRYP packet: output is unchanged (28 beats); chunk_ser_ready stays 0 until done.
- Assert chunk_ser_reset_n low at beat 10: tvalid=0 and ready=0 asynchronously. After release, ready=1 on the next clock; a new DECRYP block yields a clean 16-beat packet.
- Two back-to-back blocks with valid held high: exactly one idle cycle between packets; with CHUNK_SER_STATS_EN defined, pkt_count=2.

Source files
------------

// File: rtl/chunk_ser_pkg.sv
// Shared definitions for the chunk serializer: FSM state encoding, the
// mode encoding of encryp_decryp, and constant functions that size
// segments, packets and the word index.
package chunk_ser_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_KEY   = 3'd1;
  localparam state_t ST_NONCE = 3'd2;
  localparam state_t ST_CTR   = 3'd3;
  localparam state_t ST_DATA  = 3'd4;

  // Mode select: ENCRYP sends header + data, DECRYP sends data only.
  localparam logic ENCRYP = 1'b0;
  localparam logic DECRYP = 1'b1;

  // Number of WORD_W words in a segment of seg_w bits.
  function automatic int seg_words(input int seg_w, input int word_w);
    return seg_w / word_w;
  endfunction

  // Words in one output packet for the given mode.
  function automatic int pkt_words(input logic mode, input int key_w,
                                   input int nonce_w, input int ctr_w,
                                   input int data_w, input int word_w);
    if (mode == ENCRYP)
      return (key_w + nonce_w + ctr_w + data_w) / word_w;
    return data_w / word_w;
  endfunction

  // Largest segment word count; the word index must be able to hold it.
  function automatic int max_seg_words(input int key_w, input int nonce_w,
                                       input int ctr_w, input int data_w,
                                       input int word_w);
    int m;
    m = key_w / word_w;
    if (nonce_w / word_w > m) m = nonce_w / word_w;
    if (ctr_w / word_w > m)   m = ctr_w / word_w;
    if (data_w / word_w > m)  m = data_w / word_w;
    return m;
  endfunction

  // Word index width: clog2 of the largest segment plus one bit.
  function automatic int idx_width(input int max_words);
    return $clog2(max_words) + 1;
  endfunction

endpackage

// File: rtl/chunk_ser_out_reg.sv
// AXI-Stream output register stage. Holds tdata/tlast/tvalid and reloads
// whenever the slot is empty or the current word is being taken, so the
// word stays stable for as long as downstream stalls.
module chunk_ser_out_reg
  import chunk_ser_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              chunk_ser_clk,
  input  logic              chunk_ser_reset_n,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  input  logic              load_valid,
  input  logic              m_axis_tready,
  output logic              load_en,
  output logic [WORD_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid
);

  logic [WORD_W-1:0] tdata_reg;
  logic              tlast_reg;
  logic              tvalid_reg;

  assign load_en       = !tvalid_reg || m_axis_tready;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tlast  = tlast_reg;
  assign m_axis_tvalid = tvalid_reg;

  // Capture the next word only when the slot is free or being consumed.
  always_ff @(posedge chunk_ser_clk or negedge chunk_ser_reset_n) begin
    if (!chunk_ser_reset_n) begin
      tdata_reg  <= '0;
      tlast_reg  <= 1'b0;
      tvalid_reg <= 1'b0;
    end else if (load_en) begin
      tdata_reg  <= load_data;
      tlast_reg  <= load_last;
      tvalid_reg <= load_valid;
    end
  end

endmodule

// File: rtl/chunk_serializer.sv
// chunk_serializer: latches one data block plus an optional crypto header
// (public key, nonce, counter) and streams it out as WORD_W-bit AXI-Stream
// words, each segment most-significant word first, tlast on the final
// data word.
// Optional build macro CHUNK_SER_STATS_EN adds a 32-bit pkt_count output
// counting completed packets.
module chunk_serializer
  import chunk_ser_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int DATA_W  = 512,
  parameter int KEY_W   = 256,
  parameter int NONCE_W = 64,
  parameter int CTR_W   = 64
) (
  input  logic               chunk_ser_clk,
  input  logic               chunk_ser_reset_n,
  input  logic               chunk_ser_valid,
  output logic               chunk_ser_ready,
  input  logic               encryp_decryp,
  input  logic [KEY_W-1:0]   public_key,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [CTR_W-1:0]   counter,
  input  logic [DATA_W-1:0]  chunk_ser_data_in,
  output logic [WORD_W-1:0]  m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast
`ifdef CHUNK_SER_STATS_EN
  ,
  output logic [31:0]        pkt_count
`endif
);

  localparam int KEY_WORDS   = seg_words(KEY_W, WORD_W);
  localparam int NONCE_WORDS = seg_words(NONCE_W, WORD_W);
  localparam int CTR_WORDS   = seg_words(CTR_W, WORD_W);
  localparam int DATA_WORDS  = seg_words(DATA_W, WORD_W);
  localparam int MAX_WORDS   = max_seg_words(KEY_W, NONCE_W, CTR_W, DATA_W, WORD_W);
  localparam int IDX_W       = idx_width(MAX_WORDS);

  // Reject zero-width segments and widths that do not split into words.
  generate
    if (WORD_W <= 0 || KEY_W <= 0 || NONCE_W <= 0 || CTR_W <= 0 || DATA_W <= 0 ||
        (KEY_W % WORD_W) != 0 || (NONCE_W % WORD_W) != 0 ||
        (CTR_W % WORD_W) != 0 || (DATA_W % WORD_W) != 0) begin : g_bad_width
      $error("chunk_serializer: every segment width must be a nonzero multiple of WORD_W");
    end
  endgenerate

  // state_reg/idx_reg describe the word currently held in the output
  // register; the mode is implied by which state follows the accept, so it
  // needs no separate capture register.
  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               ready_reg;
  logic [KEY_W-1:0]   key_reg;
  logic [NONCE_W-1:0] nonce_reg;
  logic [CTR_W-1:0]   ctr_reg;
  logic [DATA_W-1:0]  data_reg;

  logic               load_en;
  logic               accept;
  logic               advance;
  logic [KEY_W-1:0]   key_src;
  logic [NONCE_W-1:0] nonce_src;
  logic [CTR_W-1:0]   ctr_src;
  logic [DATA_W-1:0]  data_src;
  logic [WORD_W-1:0]  word_next;
  logic               last_next;
  logic               valid_next;

  assign chunk_ser_ready = ready_reg;
  assign accept          = chunk_ser_valid && ready_reg;
  // Outside IDLE tvalid is always high, so load_en means "word taken".
  assign advance         = (state_reg != ST_IDLE) && load_en;

  // Next-state logic: step down through each segment, reload the index at
  // every segment boundary, return to IDLE after the final data word.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (encryp_decryp == ENCRYP) begin
            state_next = ST_KEY;
            idx_next   = IDX_W'(KEY_WORDS - 1);
          end else begin
            state_next = ST_DATA;
            idx_next   = IDX_W'(DATA_WORDS - 1);
          end
        end
      end
      ST_KEY: begin
        if (advance) begin
          if (idx_reg == '0) begin
            state_next = ST_NONCE;
            idx_next   = IDX_W'(NONCE_WORDS - 1);
          end else begin
            idx_next = idx_reg - 1'b1;
          end
        end
      end
      ST_NONCE: begin
        if (advance) begin
          if (idx_reg == '0) begin
            state_next = ST_CTR;
            idx_next   = IDX_W'(CTR_WORDS - 1);
          end else begin
            idx_next = idx_reg - 1'b1;
          end
        end
      end
      ST_CTR: begin
        if (advance) begin
          if (idx_reg == '0) begin
            state_next = ST_DATA;
            idx_next   = IDX_W'(DATA_WORDS - 1);
          end else begin
            idx_next = idx_reg - 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (advance) begin
          if (idx_reg == '0) begin
            state_next = ST_IDLE;
          end else begin
            idx_next = idx_reg - 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Word mux: on the accept cycle the first word comes straight from the
  // inputs (capture registers are not loaded yet), afterwards from the
  // captured copy so later input changes cannot leak into the packet.
  always_comb begin
    key_src    = (state_reg == ST_IDLE) ? public_key        : key_reg;
    nonce_src  = (state_reg == ST_IDLE) ? nonce             : nonce_reg;
    ctr_src    = (state_reg == ST_IDLE) ? counter           : ctr_reg;
    data_src   = (state_reg == ST_IDLE) ? chunk_ser_data_in : data_reg;
    word_next  = '0;
    case (state_next)
      ST_KEY:   word_next = WORD_W'(key_src   >> (int'(idx_next) * WORD_W));
      ST_NONCE: word_next = WORD_W'(nonce_src >> (int'(idx_next) * WORD_W));
      ST_CTR:   word_next = WORD_W'(ctr_src   >> (int'(idx_next) * WORD_W));
      ST_DATA:  word_next = WORD_W'(data_src  >> (int'(idx_next) * WORD_W));
      default:  word_next = '0;
    endcase
    last_next  = (state_next == ST_DATA) && (idx_next == '0);
    valid_next = (state_next != ST_IDLE);
  end

  // FSM, ready flag and block capture. ready follows the next state so it
  // stays low through reset and rises one clock after release.
  always_ff @(posedge chunk_ser_clk or negedge chunk_ser_reset_n) begin
    if (!chunk_ser_reset_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      ready_reg <= 1'b0;
      key_reg   <= '0;
      nonce_reg <= '0;
      ctr_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ready_reg <= (state_next == ST_IDLE);
      if (accept) begin
        key_reg   <= public_key;
        nonce_reg <= nonce;
        ctr_reg   <= counter;
        data_reg  <= chunk_ser_data_in;
      end
    end
  end

  chunk_ser_out_reg #(
    .WORD_W (WORD_W)
  ) u_out_reg (
    .chunk_ser_clk     (chunk_ser_clk),
    .chunk_ser_reset_n (chunk_ser_reset_n),
    .load_data         (word_next),
    .load_last         (last_next),
    .load_valid        (valid_next),
    .m_axis_tready     (m_axis_tready),
    .load_en           (load_en),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tvalid     (m_axis_tvalid)
  );

`ifdef CHUNK_SER_STATS_EN
  logic [31:0] pkt_count_reg;

  assign pkt_count = pkt_count_reg;

  // Count completed packets (tlast handshakes); wraps naturally at 2^32.
  always_ff @(posedge chunk_ser_clk or negedge chunk_ser_reset_n) begin
    if (!chunk_ser_reset_n)
      pkt_count_reg <= '0;
    else if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
      pkt_count_reg <= pkt_count_reg + 32'd1;
  end
`else
  // Statistics disabled: no packet counter is built.
`endif

endmodule

// File: tb/tb_chunk_serializer.sv
// Directed testbench for chunk_serializer (default parameters). Builds with
// or without CHUNK_SER_STATS_EN; the packet counter is checked only when
// the macro is defined.
module tb_chunk_serializer;

  logic         chunk_ser_clk = 1'b0;
  logic         chunk_ser_reset_n;
  logic         chunk_ser_valid;
  logic         chunk_ser_ready;
  logic         encryp_decryp;
  logic [255:0] public_key;
  logic [63:0]  nonce;
  logic [63:0]  counter;
  logic [511:0] chunk_ser_data_in;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
`ifdef CHUNK_SER_STATS_EN
  logic [31:0]  pkt_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int got_beats;
  int exp_len;
  logic [31:0]  exp_w [28];
  logic [255:0] key_c;
  logic [511:0] data_c;

  always #5 chunk_ser_clk = ~chunk_ser_clk;

  chunk_serializer dut (
`ifdef CHUNK_SER_STATS_EN
    .pkt_count         (pkt_count),
`endif
    .chunk_ser_clk     (chunk_ser_clk),
    .chunk_ser_reset_n (chunk_ser_reset_n),
    .chunk_ser_valid   (chunk_ser_valid),
    .chunk_ser_ready   (chunk_ser_ready),
    .encryp_decryp     (encryp_decryp),
    .public_key        (public_key),
    .nonce             (nonce),
    .counter           (counter),
    .chunk_ser_data_in (chunk_ser_data_in),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_enc_exp();
    exp_len   = 28;
    exp_w[0]  = 32'h00010203; exp_w[1] = 32'h04050607;
    exp_w[2]  = 32'h08090A0B; exp_w[3] = 32'h0C0D0E0F;
    exp_w[4]  = 32'h10111213; exp_w[5] = 32'h14151617;
    exp_w[6]  = 32'h18191A1B; exp_w[7] = 32'h1C1D1E1F;
    exp_w[8]  = 32'hA5A50000; exp_w[9] = 32'h00000001;
    exp_w[10] = 32'h00000000; exp_w[11] = 32'h00000001;
    for (int i = 0; i < 16; i++) exp_w[12 + i] = 32'(15 - i);
  endtask

  task automatic load_dec_exp();
    exp_len = 16;
    for (int i = 0; i < 16; i++) exp_w[i] = 32'(15 - i);
    for (int i = 16; i < 28; i++) exp_w[i] = 32'hDEADBEEF;
  endtask

  task automatic apply_block(input logic mode);
    public_key        = key_c;
    nonce             = 64'hA5A5_0000_0000_0001;
    counter           = 64'h1;
    chunk_ser_data_in = data_c;
    encryp_decryp     = mode;
    chunk_ser_valid   = 1'b1;
  endtask

  // Wait (bounded) for ready, let the handshake edge pass, optionally drop valid.
  task automatic send(input string tag, input bit keep_valid);
    int cyc = 0;
    while (chunk_ser_ready !== 1'b1 && cyc < 50) begin
      @(negedge chunk_ser_clk);
      cyc++;
    end
    check({tag, "_accept_ready"}, chunk_ser_ready, 1'b1);
    @(posedge chunk_ser_clk);
    #1;
    if (!keep_valid) chunk_ser_valid = 1'b0;
  endtask

  // Receive up to 'limit' beats, checking each against exp_w, tlast position
  // and stability of tdata/tlast/tvalid across every stall.
  task automatic recv(input string tag, input int stall_pct, input int limit,
                      input bit mutate, input bit chk_ready);
    logic [31:0] hold_d;
    logic        hold_l;
    bit          stalled;
    int          cyc;
    got_beats = 0; stalled = 0; cyc = 0; hold_d = '0; hold_l = 1'b0;
    while (got_beats < limit && cyc < 1000) begin
      @(negedge chunk_ser_clk);
      cyc++;
      if (cyc == 1) check({tag, "_first_valid"}, m_axis_tvalid, 1'b1);
      if (stalled) begin
        check({tag, "_hold_data"}, m_axis_tdata, hold_d);
        check({tag, "_hold_last"}, m_axis_tlast, hold_l);
        check({tag, "_hold_valid"}, m_axis_tvalid, 1'b1);
      end
      if (chk_ready) check({tag, "_ready_low"}, chunk_ser_ready, 1'b0);
      if (mutate) begin
        encryp_decryp = ~encryp_decryp;
        for (int k = 0; k < 16; k++) chunk_ser_data_in[k*32 +: 32] = $urandom;
      end
      m_axis_tready = ($urandom_range(99) >= stall_pct);
      if (m_axis_tvalid && m_axis_tready) begin
        $display("%s beat %0d data=%h last=%b", tag, got_beats, m_axis_tdata, m_axis_tlast);
        check($sformatf("%s_beat%0d_data", tag, got_beats), m_axis_tdata, exp_w[got_beats]);
        check($sformatf("%s_beat%0d_last", tag, got_beats), m_axis_tlast,
              (got_beats == exp_len - 1));
        got_beats++;
        stalled = 0;
      end else begin
        stalled = m_axis_tvalid;
        hold_d  = m_axis_tdata;
        hold_l  = m_axis_tlast;
      end
    end
    check({tag, "_beat_count"}, got_beats, limit);
  endtask

  initial begin
    key_c = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    for (int i = 0; i < 16; i++) data_c[i*32 +: 32] = 32'(i);
    chunk_ser_reset_n = 1'b0;
    chunk_ser_valid   = 1'b0;
    encryp_decryp     = 1'b0;
    public_key        = '0;
    nonce             = '0;
    counter           = '0;
    chunk_ser_data_in = '0;
    m_axis_tready     = 1'b1;

    // Reset state
    @(negedge chunk_ser_clk);
    check("rst_ready", chunk_ser_ready, 1'b0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, 32'h0);
    chunk_ser_reset_n = 1'b1;
    #1;
    check("rel_ready_before_clk", chunk_ser_ready, 1'b0);
    @(negedge chunk_ser_clk);
    check("rel_ready_after_clk", chunk_ser_ready, 1'b1);
    check("idle_tvalid", m_axis_tvalid, 1'b0);

    // ENCRYP, no stalls
    load_enc_exp();
    apply_block(1'b0);
    send("enc", 0);
    recv("enc", 0, 28, 0, 1);
    @(negedge chunk_ser_clk);
    check("enc_end_tvalid", m_axis_tvalid, 1'b0);
    check("enc_end_ready", chunk_ser_ready, 1'b1);

    // DECRYP, no stalls
    load_dec_exp();
    apply_block(1'b1);
    send("dec", 0);
    recv("dec", 0, 16, 0, 1);
    @(negedge chunk_ser_clk);
    check("dec_end_tvalid", m_axis_tvalid, 1'b0);
    check("dec_end_ready", chunk_ser_ready, 1'b1);

    // ENCRYP with 30% random stalls
    load_enc_exp();
    apply_block(1'b0);
    send("stall", 0);
    recv("stall", 30, 28, 0, 1);
    @(negedge chunk_ser_clk);
    check("stall_end_ready", chunk_ser_ready, 1'b1);

    // ENCRYP while mode and data inputs change every cycle
    load_enc_exp();
    apply_block(1'b0);
    send("mut", 0);
    recv("mut", 0, 28, 1, 1);
    encryp_decryp     = 1'b0;
    chunk_ser_data_in = data_c;
    @(negedge chunk_ser_clk);
    check("mut_end_ready", chunk_ser_ready, 1'b1);

    // Reset asserted while beat 10 is presented
    load_enc_exp();
    apply_block(1'b0);
    send("abort", 0);
    recv("abort", 0, 9, 0, 1);
    @(negedge chunk_ser_clk);
    check("abort_beat10_valid", m_axis_tvalid, 1'b1);
    check("abort_beat10_data", m_axis_tdata, exp_w[9]);
    chunk_ser_reset_n = 1'b0;
    #1;
    check("abort_async_tvalid", m_axis_tvalid, 1'b0);
    check("abort_async_ready", chunk_ser_ready, 1'b0);
    check("abort_async_tlast", m_axis_tlast, 1'b0);
    check("abort_async_tdata", m_axis_tdata, 32'h0);
    repeat (2) @(negedge chunk_ser_clk);
    check("abort_hold_ready", chunk_ser_ready, 1'b0);
    chunk_ser_reset_n = 1'b1;
    #1;
    check("abort_rel_ready_before", chunk_ser_ready, 1'b0);
    @(negedge chunk_ser_clk);
    check("abort_rel_ready_after", chunk_ser_ready, 1'b1);
    check("abort_rel_tvalid", m_axis_tvalid, 1'b0);
    load_dec_exp();
    apply_block(1'b1);
    send("post", 0);
    recv("post", 0, 16, 0, 1);

    // Back-to-back DECRYP blocks with valid held high, counter from reset
    @(negedge chunk_ser_clk);
    chunk_ser_reset_n = 1'b0;
    @(negedge chunk_ser_clk);
    chunk_ser_reset_n = 1'b1;
    @(negedge chunk_ser_clk);
    load_dec_exp();
    apply_block(1'b1);
    send("b2b1", 1);
    recv("b2b1", 0, 16, 0, 1);
    @(negedge chunk_ser_clk);
    check("b2b_gap_tvalid", m_axis_tvalid, 1'b0);
    check("b2b_gap_ready", chunk_ser_ready, 1'b1);
`ifdef CHUNK_SER_STATS_EN
    check("b2b_pkt_count_1", pkt_count, 32'd1);
`endif
    @(posedge chunk_ser_clk);
    #1;
    chunk_ser_valid = 1'b0;
    recv("b2b2", 0, 16, 0, 1);
    @(negedge chunk_ser_clk);
    check("b2b_end_tvalid", m_axis_tvalid, 1'b0);
    check("b2b_end_ready", chunk_ser_ready, 1'b1);
`ifdef CHUNK_SER_STATS_EN
    check("b2b_pkt_count_2", pkt_count, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
